// File: rtl/ycbcr_to_rgb.sv
// YCbCr (10-bit, signed chroma) to RGB converter: 3-stage pipeline with valid/ready backpressure.
// Define YCBCR_CLAMP_EN to saturate each channel to 0..1023 and report clip_out; otherwise channels wrap.
module ycbcr_to_rgb (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] y_in,
    input  logic [9:0] cr_in,
    input  logic [9:0] cb_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [9:0] r_out,
    output logic [9:0] g_out,
    output logic [9:0] b_out,
    output logic       clip_out,
    output logic       valid_out,
    input  logic       ready_in
);

    localparam logic signed [23:0] K_R_CR = 24'sd1437;  // 0x59D
    localparam logic signed [23:0] K_G_CB = 24'sd352;   // 0x160
    localparam logic signed [23:0] K_G_CR = 24'sd731;   // 0x2DB
    localparam logic signed [23:0] K_B_CB = 24'sd1816;  // 0x718
    localparam logic signed [23:0] ROUND  = 24'sd512;

    logic               advance;
    logic signed [23:0] cr_ext;
    logic signed [23:0] cb_ext;

    logic               v1;
    logic signed [23:0] s1_y;
    logic signed [23:0] s1_r_cr;
    logic signed [23:0] s1_g_cb;
    logic signed [23:0] s1_g_cr;
    logic signed [23:0] s1_b_cb;

    logic               v2;
    logic signed [23:0] s2_r;
    logic signed [23:0] s2_g;
    logic signed [23:0] s2_b;

    logic [9:0]         r_nxt;
    logic [9:0]         g_nxt;
    logic [9:0]         b_nxt;
    logic               clip_nxt;
    logic               unused_low;

    // The whole pipeline moves as one unit; it only stalls when the output is held.
    assign advance   = !valid_out || ready_in;
    assign ready_out = advance;

    assign cr_ext = {{14{cr_in[9]}}, cr_in};
    assign cb_ext = {{14{cb_in[9]}}, cb_in};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1      <= 1'b0;
            s1_y    <= '0;
            s1_r_cr <= '0;
            s1_g_cb <= '0;
            s1_g_cr <= '0;
            s1_b_cb <= '0;
        end else if (advance) begin
            v1 <= valid_in;
            if (valid_in) begin
                s1_y    <= {4'b0000, y_in, 10'b0000000000};
                s1_r_cr <= cr_ext * K_R_CR;
                s1_g_cb <= cb_ext * K_G_CB;
                s1_g_cr <= cr_ext * K_G_CR;
                s1_b_cb <= cb_ext * K_B_CB;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v2   <= 1'b0;
            s2_r <= '0;
            s2_g <= '0;
            s2_b <= '0;
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                s2_r <= s1_y + s1_r_cr + ROUND;
                s2_g <= s1_y - s1_g_cb - s1_g_cr + ROUND;
                s2_b <= s1_y + s1_b_cb + ROUND;
            end
        end
    end

    // Rounding bits below the binary point are consumed by the +512 and then dropped.
    assign unused_low = ^{s2_r[9:0], s2_g[9:0], s2_b[9:0]};

`ifdef YCBCR_CLAMP_EN
    logic clip_r;
    logic clip_g;
    logic clip_b;

    // v is the sum after the >>10 shift, as a 14-bit signed value.
    function automatic logic [10:0] saturate(input logic [13:0] v);
        if (v[13])
            saturate = {1'b1, 10'd0};
        else if (|v[12:10])
            saturate = {1'b1, 10'd1023};
        else
            saturate = {1'b0, v[9:0]};
    endfunction

    assign {clip_r, r_nxt} = saturate(s2_r[23:10]);
    assign {clip_g, g_nxt} = saturate(s2_g[23:10]);
    assign {clip_b, b_nxt} = saturate(s2_b[23:10]);
    assign clip_nxt        = clip_r | clip_g | clip_b;
`else
    logic unused_high;

    assign r_nxt       = s2_r[19:10];
    assign g_nxt       = s2_g[19:10];
    assign b_nxt       = s2_b[19:10];
    assign clip_nxt    = 1'b0;
    assign unused_high = ^{s2_r[23:20], s2_g[23:20], s2_b[23:20]};
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            clip_out  <= 1'b0;
        end else if (advance) begin
            valid_out <= v2;
            if (v2) begin
                r_out    <= r_nxt;
                g_out    <= g_nxt;
                b_out    <= b_nxt;
                clip_out <= clip_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Bench for ycbcr_to_rgb: integer reference model with an expected-pixel queue, plus directed literal vectors.
// Honours YCBCR_CLAMP_EN the same way the design does (saturate vs. wrap).
module tb_ycbcr_to_rgb;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [9:0] y_in, cr_in, cb_in;
    logic       valid_in;
    logic       ready_out;
    logic [9:0] r_out, g_out, b_out;
    logic       clip_out;
    logic       valid_out;
    logic       ready_in;

    int n_cmp   = 0;
    int n_bad   = 0;
    int out_cnt = 0;

    logic [30:0] exp_q[$];
    logic        stall_pend = 1'b0;
    logic [30:0] held;

    ycbcr_to_rgb dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .y_in     (y_in),
        .cr_in    (cr_in),
        .cb_in    (cb_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .r_out    (r_out),
        .g_out    (g_out),
        .b_out    (b_out),
        .clip_out (clip_out),
        .valid_out(valid_out),
        .ready_in (ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One channel: floor(sum / 1024), then saturate or wrap.
    function automatic logic [10:0] chan(input int s);
        int v;
        v = s >>> 10;
`ifdef YCBCR_CLAMP_EN
        if (v < 0)    return {1'b1, 10'd0};
        if (v > 1023) return {1'b1, 10'd1023};
`endif
        return {1'b0, v[9:0]};
    endfunction

    // Packed {clip, r, g, b}.
    function automatic logic [30:0] model(input logic [9:0] y, input logic [9:0] cr, input logic [9:0] cb);
        int yi, cri, cbi;
        logic [10:0] r, g, b;
        yi  = int'(y);
        cri = int'($signed(cr));
        cbi = int'($signed(cb));
        r = chan(yi * 1024 + 1437 * cri + 512);
        g = chan(yi * 1024 - 352 * cbi - 731 * cri + 512);
        b = chan(yi * 1024 + 1816 * cbi + 512);
        return {r[10] | g[10] | b[10], r[9:0], g[9:0], b[9:0]};
    endfunction

    // Scoreboard: sampled mid-cycle, so every signal reflects what the next edge will see.
    always @(negedge clk_in) begin
        if (rst_in) begin
            exp_q.delete();
            stall_pend = 1'b0;
        end else begin
            chk("ready_out_rule", {31'd0, ready_out}, {31'd0, (!valid_out || ready_in)});
            if (stall_pend) begin
                chk("stall_valid", {31'd0, valid_out}, 32'd1);
                chk("stall_data", {1'b0, clip_out, r_out, g_out, b_out}, {1'b0, held});
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got 0x%0h expected no pixel",
                             {clip_out, r_out, g_out, b_out});
                end else begin
                    chk("pixel", {1'b0, clip_out, r_out, g_out, b_out}, {1'b0, exp_q.pop_front()});
                end
                out_cnt++;
            end
            if (valid_in && ready_out)
                exp_q.push_back(model(y_in, cr_in, cb_in));
            stall_pend = valid_out && !ready_in;
            held       = {clip_out, r_out, g_out, b_out};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() > 0 || valid_out); i++)
            @(negedge clk_in);
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Pixel presented in one cycle with an empty pipeline: visible three cycles later, for one cycle.
    task automatic direct(input string nm, input logic [9:0] y, input logic [9:0] cr, input logic [9:0] cb,
                          input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb, input logic ec);
        @(posedge clk_in); #1;
        valid_in = 1'b1; y_in = y; cr_in = cr; cb_in = cb;
        @(posedge clk_in); #1;
        valid_in = 1'b0; y_in = $urandom; cr_in = $urandom; cb_in = $urandom;
        @(negedge clk_in);
        chk({nm, "_lat1"}, {31'd0, valid_out}, 32'd0);
        @(negedge clk_in);
        chk({nm, "_lat2"}, {31'd0, valid_out}, 32'd0);
        @(negedge clk_in);
        chk({nm, "_valid"}, {31'd0, valid_out}, 32'd1);
        chk({nm, "_rgb"}, {2'b0, r_out, g_out, b_out}, {2'b0, er, eg, eb});
        chk({nm, "_clip"}, {31'd0, clip_out}, {31'd0, ec});
        @(negedge clk_in);
        chk({nm, "_one_cycle"}, {31'd0, valid_out}, 32'd0);
    endtask

    logic [9:0] tbl_y [8] = '{10'd0,   10'd1023, 10'd0,   10'd1023, 10'd512, 10'd1,   10'd300, 10'd700};
    logic [9:0] tbl_cr[8] = '{10'h200, 10'h1FF,  10'h1FF, 10'h200,  10'h000, 10'h3FF, 10'h055, 10'h2AA};
    logic [9:0] tbl_cb[8] = '{10'h1FF, 10'h200,  10'h200, 10'h1FF,  10'h3FF, 10'h001, 10'h3C0, 10'h100};

    initial begin
        logic [30:0] e0;
        int          base;
        int          idx;
        logic        acc;

        rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        y_in = '0; cr_in = '0; cb_in = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_rgb", {2'b0, r_out, g_out, b_out}, 32'd0);
        chk("rst_clip", {31'd0, clip_out}, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_ready", {31'd0, ready_out}, 32'd1);

        direct("grey", 10'd512, 10'd0, 10'd0, 10'd512, 10'd512, 10'd512, 1'b0);
        direct("mid", 10'd100, 10'd10, 10'h3F6, 10'd114, 10'd96, 10'd82, 1'b0);
`ifdef YCBCR_CLAMP_EN
        direct("red_sat", 10'd1023, 10'd511, 10'd0, 10'd1023, 10'd658, 10'd1023, 1'b1);
        direct("neg_chroma", 10'd0, 10'h200, 10'h200, 10'd0, 10'd542, 10'd0, 1'b1);
`else
        direct("red_wrap", 10'd1023, 10'd511, 10'd0, 10'd716, 10'd658, 10'd1023, 1'b0);
        direct("neg_chroma", 10'd0, 10'h200, 10'h200, 10'd306, 10'd542, 10'd116, 1'b0);
`endif
        drain();

        // Three back-to-back pixels, output stalled for 5 cycles from the first valid_out.
        base = out_cnt;
        e0 = model(10'd200, 10'h010, 10'h3F0);
        @(posedge clk_in); #1;
        valid_in = 1'b1; y_in = 10'd200; cr_in = 10'h010; cb_in = 10'h3F0;
        @(posedge clk_in); #1;
        y_in = 10'd900; cr_in = 10'h1FF; cb_in = 10'h000;
        @(posedge clk_in); #1;
        y_in = 10'd50; cr_in = 10'h300; cb_in = 10'h100;
        @(posedge clk_in); #1;
        valid_in = 1'b0; ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("stall_hold_valid", {31'd0, valid_out}, 32'd1);
            chk("stall_ready_low", {31'd0, ready_out}, 32'd0);
            chk("stall_first_pixel", {1'b0, clip_out, r_out, g_out, b_out}, {1'b0, e0});
        end
        @(posedge clk_in); #1;
        ready_in = 1'b1;
        drain();
        chk("stall_delivered", out_cnt - base, 32'd3);

        // Continuous valid_in with ready_in toggling every cycle.
        base = out_cnt;
        idx  = 0;
        @(posedge clk_in); #1;
        valid_in = 1'b1;
        y_in = tbl_y[0]; cr_in = tbl_cr[0]; cb_in = tbl_cb[0];
        for (int g = 0; g < 400 && idx < 40; g++) begin
            @(negedge clk_in);
            acc = ready_out;
            @(posedge clk_in); #1;
            ready_in = ~ready_in;
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    y_in = tbl_y[idx]; cr_in = tbl_cr[idx]; cb_in = tbl_cb[idx];
                end else begin
                    y_in = 10'($urandom); cr_in = 10'($urandom); cb_in = 10'($urandom);
                end
            end
        end
        valid_in = 1'b0; ready_in = 1'b1;
        chk("toggle_accepted", idx, 32'd40);
        drain();
        chk("toggle_delivered", out_cnt - base, 32'd40);

        // Reset pulse with two pixels in flight: neither may emerge.
        base = out_cnt;
        @(posedge clk_in); #1;
        valid_in = 1'b1; y_in = 10'd400; cr_in = 10'h020; cb_in = 10'h020;
        @(posedge clk_in); #1;
        y_in = 10'd600; cr_in = 10'h3E0; cb_in = 10'h010;
        @(posedge clk_in); #1;
        valid_in = 1'b0; rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        chk("midrst_ready", {31'd0, ready_out}, 32'd1);
        chk("midrst_rgb", {2'b0, r_out, g_out, b_out}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("midrst_no_stale", {31'd0, valid_out}, 32'd0);
        end
        chk("midrst_delivered", out_cnt - base, 32'd0);

        direct("post_rst", 10'd512, 10'd0, 10'd0, 10'd512, 10'd512, 10'd512, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
